// File: rtl/aes_round_key_store_if.sv
// aes_round_key_store_if: key-expansion handshake and round-key read bus of aes_round_key_store
interface aes_round_key_store_if;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         exp_start;
  logic [127:0] exp_short_subkey;
  logic [127:0] exp_subkey;
  logic         exp_subkey_valid;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_data;
  logic         rk_data_valid;
  logic         rk_err;
  logic         keys_ready;
  logic         busy;
  logic         exp_timeout;
  logic         cache_hit;
  modport master (
    output key_load, cipher_key, exp_subkey, exp_subkey_valid, rk_rd_en, rk_rd_idx,
    input  exp_start, exp_short_subkey, rk_data, rk_data_valid, rk_err, keys_ready, busy,
           exp_timeout, cache_hit
  );
  modport slave (
    input  key_load, cipher_key, exp_subkey, exp_subkey_valid, rk_rd_en, rk_rd_idx,
    output exp_start, exp_short_subkey, rk_data, rk_data_valid, rk_err, keys_ready, busy,
           exp_timeout, cache_hit
  );
endinterface

// File: rtl/aes_round_key_store.sv
// aes_round_key_store: captures streamed AES round keys into a file and serves them by index; define AES_KEY_CACHE_EN to skip re-expanding an unchanged key
module aes_round_key_store #(
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic reset,
  aes_round_key_store_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, START, CAPTURE, READY} state_t;
  state_t        state;
  logic [3:0]    wr_ptr;
  logic [WW-1:0] wdog;
  logic [127:0]  key_reg;
  logic [127:0]  key_file [NUM_ROUNDS+1];
  logic          hit;
  logic          load_go;
  logic          cap_wr;
`ifdef AES_KEY_CACHE_EN
  assign hit = state == READY && bus.key_load && bus.cipher_key == key_reg;
`else
  assign hit = 1'b0;
`endif
  assign load_go = bus.key_load && (state == IDLE || state == READY) && !hit;
  assign cap_wr  = state == CAPTURE && bus.exp_subkey_valid;
  assign bus.exp_short_subkey = key_reg;
  // key file is never cleared; keys_ready alone gates what can be read
  always_ff @(posedge clk) begin
    if (!reset && load_go) key_file[0] <= bus.cipher_key;
    if (!reset && cap_wr) key_file[wr_ptr] <= bus.exp_subkey;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      wdog            <= '0;
      key_reg         <= '0;
      bus.exp_start   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.keys_ready  <= 1'b0;
      bus.exp_timeout <= 1'b0;
      bus.cache_hit   <= 1'b0;
    end else begin
      bus.exp_start   <= 1'b0;
      bus.exp_timeout <= 1'b0;
      bus.cache_hit   <= hit;
      case (state)
        IDLE, READY: if (load_go) begin
          key_reg        <= bus.cipher_key;
          bus.keys_ready <= 1'b0;
          bus.exp_start  <= 1'b1;
          bus.busy       <= 1'b1;
          state          <= START;
        end
        START: begin
          wr_ptr <= 4'd1;
          wdog   <= '0;
          state  <= CAPTURE;
        end
        CAPTURE: if (bus.exp_subkey_valid) begin
          wr_ptr <= wr_ptr + 4'd1;
          wdog   <= '0;
          if (wr_ptr == 4'(NUM_ROUNDS)) begin
            bus.keys_ready <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= READY;
          end
        end else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
          bus.exp_timeout <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end else wdog <= wdog + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
  // read path samples the pre-edge key file, so a same-cycle reload still returns old keys
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rk_data       <= '0;
      bus.rk_data_valid <= 1'b0;
      bus.rk_err        <= 1'b0;
    end else if (bus.rk_rd_en) begin
      bus.rk_data_valid <= bus.keys_ready && bus.rk_rd_idx <= 4'(NUM_ROUNDS);
      bus.rk_err        <= !(bus.keys_ready && bus.rk_rd_idx <= 4'(NUM_ROUNDS));
      bus.rk_data       <= bus.keys_ready && bus.rk_rd_idx <= 4'(NUM_ROUNDS) ? key_file[bus.rk_rd_idx] : '0;
    end else begin
      bus.rk_data_valid <= 1'b0;
      bus.rk_err        <= 1'b0;
    end
  end
endmodule

// File: tb/tb_aes_round_key_store.sv
// tb_aes_round_key_store: directed FIPS-197 vectors against aes_round_key_store; honours AES_KEY_CACHE_EN
module tb_aes_round_key_store;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] rk [11];
  logic [127:0] k0;
  logic [127:0] old_data;
  int cnt;
  aes_round_key_store_if bus();
  aes_round_key_store #(.NUM_ROUNDS(10), .TIMEOUT_CYCLES(64)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_key(input logic [127:0] k);
    bus.key_load = 1'b1;
    bus.cipher_key = k;
    tick();
    bus.key_load = 1'b0;
  endtask
  task automatic feed(input int n);
    for (int i = 1; i <= n; i++) begin
      repeat (i % 4) tick();
      bus.exp_subkey_valid = 1'b1;
      bus.exp_subkey = rk[i];
      tick();
      bus.exp_subkey_valid = 1'b0;
    end
  endtask
  task automatic rd(input logic [3:0] idx);
    bus.rk_rd_en = 1'b1;
    bus.rk_rd_idx = idx;
    tick();
    bus.rk_rd_en = 1'b0;
  endtask
  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    k0 = rk[0];
    bus.key_load = 1'b0;
    bus.cipher_key = '0;
    bus.exp_subkey = '0;
    bus.exp_subkey_valid = 1'b0;
    bus.rk_rd_en = 1'b0;
    bus.rk_rd_idx = '0;
    repeat (3) tick();
    check("rst_keys_ready", 128'(bus.keys_ready), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_exp_start", 128'(bus.exp_start), 128'd0);
    check("rst_rk_data", bus.rk_data, 128'd0);
    check("rst_flags", {bus.rk_data_valid, bus.rk_err, bus.exp_timeout, bus.cache_hit}, 128'd0);
    check("rst_short_subkey", bus.exp_short_subkey, 128'd0);
    reset = 1'b0;
    rd(4'd0);
    check("notready_err", 128'(bus.rk_err), 128'd1);
    check("notready_valid", 128'(bus.rk_data_valid), 128'd0);
    load_key(k0);
    check("load_exp_start", 128'(bus.exp_start), 128'd1);
    check("load_short_subkey", bus.exp_short_subkey, k0);
    tick();
    check("start_pulse_ends", 128'(bus.exp_start), 128'd0);
    check("capture_busy", 128'(bus.busy), 128'd1);
    feed(9);
    check("nine_not_ready", 128'(bus.keys_ready), 128'd0);
    feed(0);
    bus.exp_subkey_valid = 1'b1;
    bus.exp_subkey = rk[10];
    tick();
    bus.exp_subkey_valid = 1'b0;
    check("ready_latency", 128'(bus.keys_ready), 128'd1);
    check("ready_busy", 128'(bus.busy), 128'd0);
    rd(4'd0);
    check("idx0", bus.rk_data, rk[0]);
    check("idx0_valid", 128'(bus.rk_data_valid), 128'd1);
    rd(4'd1);
    check("idx1", bus.rk_data, rk[1]);
    rd(4'd10);
    check("idx10", bus.rk_data, rk[10]);
    check("idx10_err", 128'(bus.rk_err), 128'd0);
    tick();
    check("hold_data", bus.rk_data, rk[10]);
    check("hold_valid", 128'(bus.rk_data_valid), 128'd0);
    rd(4'd11);
    check("idx11_err", 128'(bus.rk_err), 128'd1);
    check("idx11_data", bus.rk_data, 128'd0);
    check("idx11_valid", 128'(bus.rk_data_valid), 128'd0);
    rd(4'd15);
    check("idx15_err", 128'(bus.rk_err), 128'd1);
    check("idx15_data", bus.rk_data, 128'd0);
    tick();
    check("err_pulse_ends", 128'(bus.rk_err), 128'd0);
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    tick();
    feed(3);
    cnt = 0;
    for (int i = 0; i < 200 && !bus.exp_timeout; i++) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", 128'(cnt), 128'd64);
    check("timeout_pulse", 128'(bus.exp_timeout), 128'd1);
    check("timeout_keys_ready", 128'(bus.keys_ready), 128'd0);
    check("timeout_busy", 128'(bus.busy), 128'd0);
    tick();
    check("timeout_pulse_ends", 128'(bus.exp_timeout), 128'd0);
    load_key(k0);
    tick();
    feed(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_keys_ready", 128'(bus.keys_ready), 128'd0);
    check("midreset_busy", 128'(bus.busy), 128'd0);
    load_key(k0);
    tick();
    feed(10);
    rd(4'd10);
    check("reload_idx10", bus.rk_data, rk[10]);
    rd(4'd5);
    check("reload_idx5", bus.rk_data, rk[5]);
    load_key(k0);
`ifdef AES_KEY_CACHE_EN
    check("same_key_exp_start", 128'(bus.exp_start), 128'd0);
    check("same_key_cache_hit", 128'(bus.cache_hit), 128'd1);
    check("same_key_ready", 128'(bus.keys_ready), 128'd1);
    tick();
    check("cache_hit_pulse_ends", 128'(bus.cache_hit), 128'd0);
`else
    check("same_key_exp_start", 128'(bus.exp_start), 128'd1);
    check("same_key_cache_hit", 128'(bus.cache_hit), 128'd0);
    check("same_key_ready", 128'(bus.keys_ready), 128'd0);
    tick();
    feed(10);
`endif
    check("ready_before_overlap", 128'(bus.keys_ready), 128'd1);
    bus.key_load = 1'b1;
    bus.cipher_key = ~k0;
    bus.rk_rd_en = 1'b1;
    bus.rk_rd_idx = 4'd0;
    tick();
    bus.key_load = 1'b0;
    bus.rk_rd_en = 1'b0;
    old_data = bus.rk_data;
    check("overlap_old_key", old_data, k0);
    check("overlap_valid", 128'(bus.rk_data_valid), 128'd1);
    check("overlap_exp_start", 128'(bus.exp_start), 128'd1);
    check("overlap_keys_ready", 128'(bus.keys_ready), 128'd0);
    check("overlap_short_subkey", bus.exp_short_subkey, ~k0);
    tick();
    bus.exp_subkey_valid = 1'b1;
    bus.exp_subkey = rk[3];
    bus.key_load = 1'b1;
    bus.cipher_key = k0;
    tick();
    bus.exp_subkey_valid = 1'b0;
    bus.key_load = 1'b0;
    check("capture_ignores_load", bus.exp_short_subkey, ~k0);
    check("capture_no_start", 128'(bus.exp_start), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
